// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and owner encoding.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic owner_t;

   localparam owner_t OWN_IF = 1'b0;
   localparam owner_t OWN_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Two-way winner selection: a lone requester wins, a tie goes to whoever
// was not granted last.
module arb_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic   req_if,
   input  logic   req_ls,
   input  owner_t last,
   output owner_t winner
);

   always_comb begin
      winner = OWN_IF;
      if (req_if && req_ls) begin
         winner = (last == OWN_IF) ? OWN_LS : OWN_IF;
      end else if (req_ls) begin
         winner = OWN_LS;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port, one
// outstanding transaction. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,

   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_be,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,

   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_t state_q;
   state_t state_d;
   owner_t owner_q;
   owner_t last_grant;
   owner_t winner;
   logic   gnt;
   logic   rvalid;
   logic   claim;

   assign claim = (state_q == IDLE) && (if_req || ls_req);

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= OWN_IF;
      end else if (claim) begin
         last_grant <= winner;
      end
   end
`else
   // A fixed "fetch was last" makes every tie resolve to load/store.
   assign last_grant = OWN_IF;
`endif

   arb_pick2 u_pick (
      .req_if (if_req),
      .req_ls (ls_req),
      .last   (last_grant),
      .winner (winner)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
      end else begin
         state_q <= state_d;
         if (claim) begin
            owner_q <= winner;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      gnt       = 1'b0;
      rvalid    = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || ls_req) begin
               state_d = REQ;
            end
         end
         REQ: begin
            mem_req = 1'b1;
            if (owner_q == OWN_LS) begin
               mem_we    = ls_we;
               mem_addr  = ls_addr;
               mem_wdata = ls_wdata;
               mem_be    = ls_be;
            end else begin
               mem_addr  = if_addr;
               mem_be    = '1;
            end
            // A response in the grant cycle closes the transaction at once.
            if (mem_gnt) begin
               gnt = 1'b1;
               if (mem_rvalid) begin
                  rvalid  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (mem_rvalid) begin
               rvalid  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_gnt    = gnt    && (owner_q == OWN_IF);
   assign ls_gnt    = gnt    && (owner_q == OWN_LS);
   assign if_rvalid = rvalid && (owner_q == OWN_IF);
   assign ls_rvalid = rvalid && (owner_q == OWN_LS);
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byte-enable width SHALL be DATA_W/8.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 if_req/if_addr  input  1/ADDR_W  SHALL be the instruction-fetch read request and address.
REQ-006 if_gnt/if_rvalid/if_rdata  output  1/1/DATA_W  SHALL be the fetch accept pulse, response valid pulse and read data.
REQ-007 ls_req/ls_we/ls_addr/ls_wdata/ls_be  input  1/1/ADDR_W/DATA_W/DATA_W/8  SHALL be the load/store request fields.
REQ-008 ls_gnt/ls_rvalid/ls_rdata  output  1/1/DATA_W  SHALL be the load/store accept pulse, response valid pulse and read data.
REQ-009 mem_req/mem_we/mem_addr/mem_wdata/mem_be  output  1/1/ADDR_W/DATA_W/DATA_W/8  SHALL drive the shared memory port.
REQ-010 mem_gnt/mem_rvalid/mem_rdata  input  1/1/DATA_W  SHALL be the memory accept, response valid (read data or write ack) and read data.

Function
REQ-011 FSM SHALL have states IDLE, REQ, RESP, with at most one outstanding memory transaction.
REQ-012 IDLE: if any requester asserts req, the arbiter SHALL register the winner as owner and enter REQ next cycle; otherwise it SHALL remain in IDLE.
REQ-013 REQ: mem_req SHALL be 1 and mem_we/addr/wdata/be SHALL be muxed combinationally from the owner (mem_we=0, mem_be=all-ones for fetch).
REQ-014 REQ: the cycle mem_gnt=1, the owner's gnt SHALL pulse for exactly that cycle and the FSM SHALL enter RESP.
REQ-015 RESP: mem_req SHALL be 0; on mem_rvalid=1 the owner's rvalid SHALL pulse with rdata=mem_rdata in that cycle, and the FSM SHALL return to IDLE.
REQ-016 mem_gnt and mem_rvalid both 1 in REQ SHALL complete the transaction in that cycle (gnt and rvalid pulse together) and return to IDLE.
REQ-017 mem_rvalid outside RESP (or the REQ case of REQ-016) SHALL be ignored.
REQ-018 The non-owner's gnt and rvalid SHALL be 0 at all times; rdata outputs SHALL equal mem_rdata unconditionally.
REQ-019 Requesters SHALL hold req and request fields stable until gnt; dropping req earlier is a protocol violation with undefined results.
REQ-020 Minimum latency SHALL be: req seen in IDLE at cycle N -> mem_req at N+1 -> gnt at N+1 if mem_gnt=1 -> next arbitration at N+2 or later.
REQ-021 Writes SHALL also wait in RESP for mem_rvalid (write acknowledge) before a new arbitration.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force state IDLE, owner=fetch, last-grant=fetch; all outputs SHALL read 0 (except rdata, which follows mem_rdata).
REQ-023 Reset asserted in REQ or RESP SHALL abandon the transaction; a mem_rvalid arriving after reset release SHALL be ignored per REQ-017.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL be granted to the requester not granted most recently; last-grant SHALL update on each owner registration.
REQ-025 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to load/store (fixed priority), and no last-grant register SHALL exist.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE/REQ/RESP) and the owner encoding (OWN_IF=0, OWN_LS=1).
REQ-027 The winner selection SHALL be one sub-module, arb_pick2, taking two requests plus last-grant and returning the winner.

Verification
REQ-028 Fetch-only read: if_req=1, if_addr=0x100, mem_gnt=1 in the first REQ cycle, mem_rvalid=1 two cycles later with 0xDEADBEEF -> if_gnt one pulse, if_rvalid one pulse, if_rdata=0xDEADBEEF, mem_we=0.
REQ-029 LS write: ls_we=1, ls_addr=0x2000, ls_wdata=0x12345678, ls_be=0x3, mem_gnt delayed 3 cycles -> mem_req held 3 cycles with stable fields, then ls_gnt one pulse; FSM stays in RESP until mem_rvalid.
REQ-030 Simultaneous continuous requests, 4 transactions: with ARB_ROUND_ROBIN_EN grants SHALL be LS,IF,LS,IF; without it LS,LS,LS,LS.
REQ-031 mem_gnt and mem_rvalid both 1 in the same REQ cycle -> gnt and rvalid pulse together; next mem_req no earlier than 2 cycles later.
REQ-032 rst_n=0 during RESP, then mem_rvalid=1 after release -> no rvalid pulse, state IDLE, all outputs 0.
REQ-033 Spurious mem_rvalid=1 in IDLE -> if_rvalid=ls_rvalid=0.
